re_scheduler: RTL and testbench

Single-clock scheduler that shares the readout read-enable path between `NREQ` requesters (event-buffer channels). It arbitrates round-robin and emits one-`clk` read-enable pulses into the fast-to-slow read-enable stretcher. It spaces the pulses so that no pulse is lost at the configured `clk`:`bclk` ratio (1:1, 2:1 or 4:1). It sits between the channel request logic and the stretcher input, in the `clk` domain.

---
 rtl/re_scheduler.sv | 129 ++++++++++++
 tb/tb_re_scheduler.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/re_scheduler.sv
// Purpose: round-robin scheduler that shares one read-enable pulse path between NREQ requesters.
// Latency: req sampled in IDLE -> gnt/re_out high for the following cycle only (registered).
// Backpressure: after each grant the block stays busy for 2R cycles plus one IDLE cycle, so pulses are spaced 2R+1 clk.
module re_scheduler #(
    parameter int NREQ = 4,
    parameter int CNTW = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic [1:0]              ratio,
    input  logic [NREQ-1:0]         req,
    input  logic                    clr_cnt,
    output logic [NREQ-1:0]         gnt,
    output logic                    re_out,
    output logic [$clog2(NREQ)-1:0] gnt_idx,
    output logic                    busy,
    output logic [CNTW-1:0]         gnt_cnt
);
    localparam int IW = $clog2(NREQ);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t          state;
    state_t          next_state;
    logic [IW-1:0]   ptr;
    logic [IW-1:0]   win_idx;
    logic            win_vld;
    logic [IW:0]     cand;
    logic            take;
    logic [NREQ-1:0] gnt_q;
    logic [1:0]      ratio_lat;
    logic [2:0]      hold_cnt;
    logic [2:0]      hold_load;

    // Round-robin winner: first asserted req scanning upward from ptr, wrapping at NREQ.
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        cand    = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = {1'b0, ptr} + (IW+1)'(k);
            if (cand >= (IW+1)'(NREQ)) begin
                cand = cand - (IW+1)'(NREQ);
            end
            if (!win_vld && req[cand[IW-1:0]]) begin
                win_vld = 1'b1;
                win_idx = cand[IW-1:0];
            end
        end
    end

    assign take = (state == IDLE) && en && win_vld;

    // HOLD length comes from the ratio captured with the grant, so mid-grant ratio changes wait for the next grant.
    always_comb begin
        case (ratio_lat)
            2'b00:   hold_load = 3'd0;
            2'b01:   hold_load = 3'd2;
            default: hold_load = 3'd6;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: a started grant always runs ISSUE and HOLD to completion.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (take) next_state = ISSUE;
            ISSUE:   next_state = HOLD;
            HOLD:    if (hold_cnt == 3'd0) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Outputs are decoded from registered state only, so they are glitch-free.
    always_comb begin
        gnt    = (state == ISSUE) ? gnt_q : '0;
        re_out = (state == ISSUE);
        busy   = (state == ISSUE) || (state == HOLD);
    end

    // Grant capture, round-robin pointer advance and HOLD countdown.
    always_ff @(posedge clk) begin
        if (rst) begin
            gnt_q     <= '0;
            gnt_idx   <= '0;
            ptr       <= '0;
            ratio_lat <= 2'b00;
            hold_cnt  <= 3'd0;
        end else begin
            if (take) begin
                gnt_q     <= NREQ'(1) << win_idx;
                gnt_idx   <= win_idx;
                ptr       <= (win_idx == IW'(NREQ - 1)) ? '0 : win_idx + IW'(1);
                ratio_lat <= ratio;
            end
            if (state == ISSUE) begin
                hold_cnt <= hold_load;
            end else if (state == HOLD && hold_cnt != 3'd0) begin
                hold_cnt <= hold_cnt - 3'd1;
            end
        end
    end

    // Saturating grant counter; a clear in the same cycle as ISSUE wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            gnt_cnt <= '0;
        end else if (clr_cnt) begin
            gnt_cnt <= '0;
        end else if (state == ISSUE && gnt_cnt != {CNTW{1'b1}}) begin
            gnt_cnt <= gnt_cnt + CNTW'(1);
        end
    end

endmodule

// File: tb/tb_re_scheduler.sv
// Purpose: checks re_scheduler against a timeline model of grants, spacing and counting.
// Latency: model predicts outputs visible 1 time unit after each rising edge.
// Backpressure: model treats every edge within 2R edges of a grant as non-sampling.
module tb_re_scheduler;
    localparam int NREQ = 4;
    localparam int CNTW = 8;
    localparam int CMAX = (1 << CNTW) - 1;

    logic            clk = 1'b0;
    logic            rst;
    logic            en;
    logic [1:0]      ratio;
    logic [NREQ-1:0] req;
    logic            clr_cnt;
    logic [NREQ-1:0] gnt;
    logic            re_out;
    logic [1:0]      gnt_idx;
    logic            busy;
    logic [CNTW-1:0] gnt_cnt;

    re_scheduler #(.NREQ(NREQ), .CNTW(CNTW)) dut (
        .clk(clk), .rst(rst), .en(en), .ratio(ratio), .req(req), .clr_cnt(clr_cnt),
        .gnt(gnt), .re_out(re_out), .gnt_idx(gnt_idx), .busy(busy), .gnt_cnt(gnt_cnt)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: grants happen only at free edges; each grant blocks the next 2R edges.
    int              m_quiet = 0;
    int              m_ptr   = 0;
    int              m_cnt   = 0;
    logic [NREQ-1:0] m_gnt   = '0;
    logic [1:0]      m_idx   = '0;
    logic            m_busy  = 1'b0;
    logic            m_issue = 1'b0;
    int              cyc       = 0;
    int              last_rise = 0;
    int              prev_rise = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        int r;
        int w;
        if (rst) begin
            m_gnt = '0; m_busy = 1'b0; m_idx = '0; m_ptr = 0;
            m_cnt = 0; m_quiet = 0; m_issue = 1'b0;
        end else begin
            if (clr_cnt) m_cnt = 0;
            else if (m_issue && m_cnt < CMAX) m_cnt = m_cnt + 1;
            m_issue = 1'b0;
            m_gnt   = '0;
            if (m_quiet > 0) begin
                m_quiet = m_quiet - 1;
                m_busy  = (m_quiet > 0);
            end else if (en && req != '0) begin
                r = (ratio == 2'b00) ? 1 : (ratio == 2'b01) ? 2 : 4;
                w = -1;
                for (int k = 0; k < NREQ; k++) begin
                    if (w < 0 && req[(m_ptr + k) % NREQ]) w = (m_ptr + k) % NREQ;
                end
                m_gnt   = NREQ'(1) << w;
                m_idx   = 2'(w);
                m_ptr   = (w + 1) % NREQ;
                m_quiet = 2 * r;
                m_busy  = 1'b1;
                m_issue = 1'b1;
            end else begin
                m_busy = 1'b0;
            end
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
        cyc++;
        chk("gnt", 32'(gnt), 32'(m_gnt));
        chk("re_out", 32'(re_out), 32'(|m_gnt));
        chk("busy", 32'(busy), 32'(m_busy));
        chk("gnt_idx", 32'(gnt_idx), 32'(m_idx));
        chk("gnt_cnt", 32'(gnt_cnt), 32'(m_cnt));
        if (re_out) begin
            prev_rise = last_rise;
            last_rise = cyc;
        end
    endtask

    task automatic wait_re();
        int n;
        n = 0;
        tick();
        while (!re_out && n < 40) begin
            tick();
            n++;
        end
        chk("re_timeout", 32'(re_out), 32'd1);
    endtask

    logic [NREQ-1:0] rr_seq [4];
    int nre;

    initial begin
        rr_seq[0] = 4'b0010; rr_seq[1] = 4'b0100; rr_seq[2] = 4'b1000; rr_seq[3] = 4'b0001;
        rst = 1'b1; en = 1'b1; ratio = 2'b00; req = 4'b1111; clr_cnt = 1'b0;

        // Reset held three cycles with all requests present.
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_gnt", 32'(gnt), 32'd0);
            chk("rst_cnt", 32'(gnt_cnt), 32'd0);
        end
        rst = 1'b0;
        tick();
        chk("first_gnt", 32'(gnt), 32'b0001);

        // Round-robin with R=1.
        for (int g = 0; g < 4; g++) begin
            wait_re();
            chk("rr_seq", 32'(gnt), 32'(rr_seq[g]));
            chk("rr_space", 32'(last_rise - prev_rise), 32'd3);
        end
        tick();
        chk("rr_cnt", 32'(gnt_cnt), 32'd5);

        // Spacing at R=2 and R=4 with a single requester.
        req = 4'b0001; ratio = 2'b01;
        wait_re(); wait_re();
        chk("space_r2", 32'(last_rise - prev_rise), 32'd5);
        ratio = 2'b10;
        wait_re(); wait_re();
        chk("space_r4", 32'(last_rise - prev_rise), 32'd9);

        // Ratio change during HOLD applies only to the next grant.
        wait_re();
        tick(); tick();
        ratio = 2'b00;
        wait_re();
        chk("ratio_hold", 32'(last_rise - prev_rise), 32'd9);
        wait_re();
        chk("ratio_next", 32'(last_rise - prev_rise), 32'd3);

        // Reset in the third HOLD cycle of an R=4 grant.
        req = 4'b1111; ratio = 2'b10;
        wait_re();
        chk("pre_rst_gnt", 32'(gnt), 32'b0010);
        tick(); tick(); tick();
        rst = 1'b1;
        tick();
        chk("rst_hold_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        tick();
        chk("rst_ptr0", 32'(gnt), 32'b0001);

        // en dropped during ISSUE: pulse completes, then no grants until en returns.
        ratio = 2'b00; req = 4'b0110;
        wait_re();
        en = 1'b0;
        nre = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (re_out) nre++;
        end
        chk("en_block", 32'(nre), 32'd0);
        en = 1'b1;
        tick();
        chk("en_resume", 32'(re_out), 32'd1);

        // Counter saturation.
        req = 4'b1111;
        for (int i = 0; i < 2000 && gnt_cnt != CNTW'(CMAX); i++) tick();
        chk("cnt_reach_max", 32'(gnt_cnt), 32'(CMAX));
        wait_re(); wait_re(); wait_re();
        tick();
        chk("cnt_sat", 32'(gnt_cnt), 32'(CMAX));

        // Clear coinciding with ISSUE.
        wait_re();
        clr_cnt = 1'b1;
        tick();
        clr_cnt = 1'b0;
        chk("clr_win", 32'(gnt_cnt), 32'd0);

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            req     = NREQ'($urandom);
            en      = ($urandom_range(7) != 0);
            ratio   = 2'($urandom);
            clr_cnt = ($urandom_range(49) == 0);
            rst     = ($urandom_range(99) == 0);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
